// File: rtl/sram_burst_rd_pkg.sv
// sram_burst_rd_pkg: default geometry shared with the PE feeders and the read FSM encoding
package sram_burst_rd_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_ENTRIES_DEF  = 1024;
  localparam int LANES_DEF      = 2;
  localparam int MAX_BEATS_DEF  = 16;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/sram_out_fifo.sv
// sram_out_fifo: 2-entry stream buffer with push/pop/count, output taken straight from storage
module sram_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_pop  = pop_i && count_o != 2'd0;
  assign do_push = push_i && (count_o != 2'd2 || do_pop);
  assign dout_o  = mem[rp];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      count_o <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din_i;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      count_o <= count_o + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/sram_burst_rd.sv
// sram_burst_rd: word-write SRAM with LANES-wide burst reads over a backpressured valid/ready stream
module sram_burst_rd
  import sram_burst_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_ENTRIES  = N_ENTRIES_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int MAX_BEATS  = MAX_BEATS_DEF,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int BW = $clog2(MAX_BEATS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_req_valid_i,
  output logic                        rd_req_ready_o,
  input  logic [AW-1:0]               rd_base_i,
  input  logic [BW-1:0]               rd_beats_i,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [LANES*DATA_WIDTH-1:0] rd_data_o,
  output logic                        rd_last_o,
  output logic                        busy_o
);
  localparam int LB  = $clog2(LANES);
  localparam int LBW = LANES > 1 ? LB : 1;
  localparam int IW  = AW - LB;
  localparam int DW  = LANES * DATA_WIDTH;
  state_e state;
  logic [AW-1:0] ptr;
  logic [BW-1:0] left;
  logic [LBW-1:0] rot_q;
  logic vld_q, last_q, pop, issue, start, fin, run_nxt;
  logic [1:0] cnt, occ_nxt;
  logic [DATA_WIDTH-1:0] bank_q [LANES];
  logic [DW-1:0] beat;
  assign rd_req_ready_o = state == IDLE;
  assign pop     = rd_valid_o && rd_ready_i;
  assign occ_nxt = cnt + 2'(vld_q) - 2'(pop);
  // Credit: at most two beats may be in the RAM register or the FIFO after this edge.
  assign issue   = state == RUN && occ_nxt < 2'd2;
  assign start   = rd_req_ready_o && rd_req_valid_i && rd_beats_i != '0;
  assign fin     = issue && left == BW'(1);
  assign run_nxt = start || (state == RUN && !fin);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      ptr    <= '0;
      left   <= '0;
      rot_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= run_nxt ? RUN : IDLE;
      ptr    <= start ? rd_base_i : issue ? ptr + AW'(LANES) : ptr;
      left   <= start ? rd_beats_i : issue ? left - BW'(1) : left;
      rot_q  <= issue ? LBW'(ptr & AW'(LANES - 1)) : rot_q;
      vld_q  <= issue;
      last_q <= fin;
      busy_o <= run_nxt || issue || occ_nxt != 2'd0;
    end
  end
  // Bank b holds words with addr mod LANES == b; each lane of a beat lands in a distinct bank.
  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [N_ENTRIES/LANES];
    logic [AW-1:0] ra;
    assign ra = ptr + ((AW'(b) - ptr) & AW'(LANES - 1));
    always_ff @(posedge clk_i) begin
      if (wr_en_i && (wr_addr_i & AW'(LANES - 1)) == AW'(b)) mem[IW'(wr_addr_i >> LB)] <= wr_data_i;
      if (issue) bank_q[b] <= mem[IW'(ra >> LB)];
    end
  end
  always_comb begin
    beat = '0;
    for (int i = 0; i < LANES; i++) beat[i*DATA_WIDTH +: DATA_WIDTH] = bank_q[rot_q + LBW'(i)];
  end
  sram_out_fifo #(.W(DW + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (vld_q),
    .din_i   ({last_q, beat}),
    .pop_i   (pop),
    .dout_o  ({rd_last_o, rd_data_o}),
    .count_o (cnt)
  );
  assign rd_valid_o = cnt != 2'd0;
endmodule
